// File: rtl/reg_readout_pkg.sv
// Shared constants and types for the register-bank read-out path.
package reg_readout_pkg;

  localparam int DEF_NREGS = 8;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_IDXW  = 3;

  // Two-state sequencer: waiting for a start, or streaming words.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

endpackage

// File: rtl/reg_readout_seq_if.sv
// Valid/ready word stream carrying a register value and its index.
interface reg_readout_seq_if
  import reg_readout_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDXW  = DEF_IDXW
);

  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data_out;
  logic [IDXW-1:0]  idx_out;

  modport master (output valid, output data_out, output idx_out, input  ready);
  modport slave  (input  valid, input  data_out, input  idx_out, output ready);

endinterface

// File: rtl/reg_word_mux.sv
// Combinational NREGS:1 word selector over the flattened register bank.
module reg_word_mux
  import reg_readout_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDXW  = DEF_IDXW
) (
  input  logic [NREGS*WIDTH-1:0] regs_flat,
  input  logic [IDXW-1:0]        sel,
  output logic [WIDTH-1:0]       word
);

  // Register i lives at bits [i*WIDTH +: WIDTH].
  assign word = regs_flat[int'(sel)*WIDTH +: WIDTH];

endmodule

// File: rtl/reg_readout_seq.sv
// Streams bank registers first..last (wrapping) over a valid/ready port.
module reg_readout_seq
  import reg_readout_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDXW  = DEF_IDXW
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [NREGS*WIDTH-1:0] regs_flat,
  input  logic                   start,
  input  logic [IDXW-1:0]        first_idx,
  input  logic [IDXW-1:0]        last_idx,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  reg_readout_seq_if.master      out_if
);

  state_e           state_q, state_d;
  logic             valid_q, valid_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic [IDXW-1:0]  idx_q,   idx_d;
  logic [IDXW-1:0]  last_q,  last_d;
  logic [WIDTH-1:0] data_q,  data_d;

  logic [IDXW-1:0]  sel_idx;
  logic [WIDTH-1:0] sel_word;

  // One selector serves both the first load and every advance; the index
  // wraps naturally because NREGS is a power of two.
  assign sel_idx = (state_q == ST_IDLE) ? first_idx : idx_q + 1'b1;

  reg_word_mux #(
    .NREGS (NREGS),
    .WIDTH (WIDTH),
    .IDXW  (IDXW)
  ) u_word_mux (
    .regs_flat (regs_flat),
    .sel       (sel_idx),
    .word      (sel_word)
  );

  // Next-state and next-output decode for the sequencer.
  always_comb begin
    // NOTE: every _d gets a default first, so no path leaves one unassigned
    // and no latch is inferred.
    state_d = state_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    idx_d   = idx_q;
    last_d  = last_q;
    data_d  = data_q;

    unique case (state_q)
      ST_IDLE: begin
        // abort is meaningless here; start alone decides.
        if (start) begin
          last_d  = last_idx;
          idx_d   = first_idx;
          data_d  = sel_word;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (abort) begin
          // A same-edge accept is the final word; no completion pulse.
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (valid_q && out_if.ready) begin
          if (idx_q == last_q) begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d  = sel_idx;
            data_d = sel_word;
          end
        end
        // Stalled: word and index are held, never re-sampled.
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
      last_q  <= '0;
      data_q  <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop sees pre-edge values.
      state_q <= state_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  assign out_if.valid    = valid_q;
  assign out_if.data_out = data_q;
  assign out_if.idx_out  = idx_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_reg_readout_seq.sv
// Bench for reg_readout_seq: directed scenarios plus random traffic, all
// compared against a queue-based model of the read-out sequence.
module tb_reg_readout_seq;
  import reg_readout_pkg::*;

  localparam int NREGS = 8;
  localparam int WIDTH = 16;
  localparam int IDXW  = 3;

  logic                   clock;
  logic                   resetn;
  logic [NREGS*WIDTH-1:0] regs_flat;
  logic                   start;
  logic [IDXW-1:0]        first_idx;
  logic [IDXW-1:0]        last_idx;
  logic                   abort;
  logic                   busy;
  logic                   done;

  reg_readout_seq_if #(.WIDTH(WIDTH), .IDXW(IDXW)) bus ();

  reg_readout_seq #(.NREGS(NREGS), .WIDTH(WIDTH), .IDXW(IDXW)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .regs_flat (regs_flat),
    .start     (start),
    .first_idx (first_idx),
    .last_idx  (last_idx),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .out_if    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register bank: posedge registers with one write port.
  logic [WIDTH-1:0] bank [NREGS];
  logic             load_init;
  logic             wr_en;
  logic [IDXW-1:0]  wr_idx;
  logic [WIDTH-1:0] wr_data;

  always @(posedge clock) begin
    if (load_init) begin
      for (int i = 0; i < NREGS; i++) bank[i] <= WIDTH'(16'h1000 + i);
    end else if (wr_en) begin
      bank[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NREGS; i++) regs_flat[i*WIDTH +: WIDTH] = bank[i];
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: the outstanding sequence is a list of indices still to be shown.
  bit               m_valid, m_busy, m_done;
  int               m_idx;
  logic [WIDTH-1:0] m_data;
  int               m_todo[$];

  task automatic model_clear();
    m_valid = 0; m_busy = 0; m_done = 0; m_idx = 0; m_data = '0;
    m_todo.delete();
  endtask

  // Outcome of the coming edge, from current inputs and pre-edge bank.
  task automatic model_step();
    int n;
    m_done = 0;
    if (!m_busy) begin
      if (start) begin
        n = ((int'(last_idx) - int'(first_idx) + NREGS) % NREGS) + 1;
        m_todo.delete();
        for (int k = 0; k < n; k++) m_todo.push_back((int'(first_idx) + k) % NREGS);
        m_idx   = m_todo.pop_front();
        m_data  = bank[m_idx];
        m_valid = 1;
        m_busy  = 1;
      end
    end else if (abort) begin
      m_valid = 0;
      m_busy  = 0;
      m_todo.delete();
    end else if (bus.ready) begin
      if (m_todo.size() == 0) begin
        m_valid = 0;
        m_busy  = 0;
        m_done  = 1;
      end else begin
        m_idx  = m_todo.pop_front();
        m_data = bank[m_idx];
      end
    end
  endtask

  // Inputs are set at the falling edge; outputs are compared at the next one.
  task automatic cycle();
    model_step();
    @(posedge clock);
    @(negedge clock);
    check("valid", 32'(bus.valid), 32'(m_valid));
    check("busy",  32'(busy),      32'(m_busy));
    check("done",  32'(done),      32'(m_done));
    if (m_valid) begin
      check("idx_out",  32'(bus.idx_out),  32'(m_idx));
      check("data_out", 32'(bus.data_out), 32'(m_data));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(bus.valid),    32'd0);
    check({tag, "_busy"},  32'(busy),         32'd0);
    check({tag, "_done"},  32'(done),         32'd0);
    check({tag, "_data"},  32'(bus.data_out), 32'd0);
    check({tag, "_idx"},   32'(bus.idx_out),  32'd0);
  endtask

  task automatic go(input int f, input int l);
    start = 1'b1; first_idx = IDXW'(f); last_idx = IDXW'(l);
    cycle();
    start = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; first_idx = '0; last_idx = '0; abort = 1'b0;
    bus.ready = 1'b0; load_init = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_data = '0;
    model_clear();
    @(posedge clock);
    @(negedge clock);
    check_reset_outputs("por");
    load_init = 1'b0;
    resetn = 1'b1;

    // Short range with continuous ready.
    bus.ready = 1'b1;
    go(2, 4);
    repeat (4) cycle();

    // Range that wraps through 7 -> 0.
    go(6, 1);
    repeat (5) cycle();

    // Single word.
    go(5, 5);
    repeat (2) cycle();

    // Full bank; start held high with new indices while busy, then
    // honoured only once the sequence has completed.
    go(3, 2);
    start = 1'b1; first_idx = 3'd0; last_idx = 3'd0;
    repeat (10) cycle();
    start = 1'b0;
    repeat (2) cycle();

    // Stalls while the bank changes; same-edge write is not seen.
    go(0, 3);
    bus.ready = 1'b1; cycle();
    bus.ready = 1'b0; wr_en = 1'b1; wr_idx = 3'd0; wr_data = 16'hBEEF; cycle();
    wr_idx = 3'd1; cycle();
    bus.ready = 1'b1; wr_idx = 3'd2; cycle();
    wr_idx = 3'd3; wr_data = 16'hCAFE; cycle();
    wr_en = 1'b0; repeat (2) cycle();

    // Abort at idx 2 together with an accept; ignored start while busy.
    go(0, 5);
    start = 1'b1; first_idx = 3'd7; last_idx = 3'd7; cycle();
    start = 1'b0; cycle();
    abort = 1'b1; cycle();
    abort = 1'b0; repeat (2) cycle();

    // Asynchronous reset in the middle of a stalled sequence.
    bus.ready = 1'b0;
    go(0, 7);
    cycle();
    #2 resetn = 1'b0;
    #1 check_reset_outputs("async");
    model_clear();
    @(negedge clock);
    check_reset_outputs("held");
    resetn = 1'b1;
    bus.ready = 1'b1;
    go(1, 2);
    repeat (3) cycle();

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      start     = ($urandom_range(0, 3) == 0);
      first_idx = IDXW'($urandom_range(0, NREGS - 1));
      last_idx  = IDXW'($urandom_range(0, NREGS - 1));
      abort     = ($urandom_range(0, 24) == 0);
      bus.ready = ($urandom_range(0, 2) != 0);
      wr_en     = ($urandom_range(0, 1) == 1);
      wr_idx    = IDXW'($urandom_range(0, NREGS - 1));
      wr_data   = WIDTH'($urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
